// File: rtl/csr_file.sv
// Control/status register file for the LoongArch pipeline.
// Serves WB-stage CSR reads and masked writes, records exception/ertn side
// effects, samples interrupt lines and runs the stable timer.
module csr_file #(
    parameter int unsigned TIMER_W  = 32,
    parameter logic [12:0] LIE_MASK = 13'h1bff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        ws_ex,
    input  logic [31:0] ws_pc,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    input  logic [31:0] ws_vaddr,
    input  logic [31:0] coreid_in,
    input  logic        ertn,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] era_entry
);

    localparam logic [13:0] CsrCrmd   = 14'h000;
    localparam logic [13:0] CsrPrmd   = 14'h001;
    localparam logic [13:0] CsrEcfg   = 14'h004;
    localparam logic [13:0] CsrEstat  = 14'h005;
    localparam logic [13:0] CsrEra    = 14'h006;
    localparam logic [13:0] CsrBadv   = 14'h007;
    localparam logic [13:0] CsrEentry = 14'h00c;
    localparam logic [13:0] CsrSave0  = 14'h030;
    localparam logic [13:0] CsrSave1  = 14'h031;
    localparam logic [13:0] CsrSave2  = 14'h032;
    localparam logic [13:0] CsrSave3  = 14'h033;
    localparam logic [13:0] CsrTid    = 14'h040;
    localparam logic [13:0] CsrTcfg   = 14'h041;
    localparam logic [13:0] CsrTval   = 14'h042;
    localparam logic [13:0] CsrTiclr  = 14'h044;

    localparam logic [5:0] EcodeAde = 6'h08;
    localparam logic [5:0] EcodeAle = 6'h09;
    localparam logic [8:0] EsubAdef = 9'h000;
    localparam logic [8:0] EsubAdem = 9'h001;

    // Software-writable bits of each register; everything else holds 0.
    localparam logic [31:0] CrmdWmask   = 32'h0000_01ff;
    localparam logic [31:0] PrmdWmask   = 32'h0000_0007;
    localparam logic [31:0] EcfgWmask   = {19'b0, LIE_MASK};
    localparam logic [31:0] EstatWmask  = 32'h0000_0003;
    localparam logic [31:0] EentryWmask = 32'hffff_ffc0;
    localparam logic [63:0] TcfgWide    = (64'd1 << TIMER_W) - 64'd1;
    localparam logic [31:0] TcfgWmask   = TcfgWide[31:0];

    localparam logic [TIMER_W-1:0] TvalOnes = {TIMER_W{1'b1}};

    logic [31:0]       crmd_q, crmd_d;
    logic [31:0]       prmd_q, prmd_d;
    logic [31:0]       ecfg_q, ecfg_d;
    logic [31:0]       estat_q, estat_d;
    logic [31:0]       era_q, era_d;
    logic [31:0]       badv_q, badv_d;
    logic [31:0]       eentry_q, eentry_d;
    logic [3:0][31:0]  save_q, save_d;
    logic [31:0]       tid_q, tid_d;
    logic [31:0]       tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;

    logic tcfg_wr;
    logic timer_fire;
    logic ticlr_clr;

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wmask,
                                           input logic [31:0] wval, input logic [31:0] field);
        return (old & ~(wmask & field)) | (wval & wmask & field);
    endfunction

    // Next-state: interrupt sampling, exception/ertn, software writes, timer.
    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        ecfg_d     = ecfg_q;
        estat_d    = estat_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        save_d     = save_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        tcfg_wr    = 1'b0;
        timer_fire = 1'b0;
        ticlr_clr  = 1'b0;

        estat_d[9:2]  = hw_int_in;
        estat_d[10]   = 1'b0;
        estat_d[12]   = ipi_int_in;

        if (ws_ex) begin
            prmd_d[2:0]    = crmd_q[2:0];
            crmd_d[2:0]    = 3'b000;
            era_d          = ws_pc;
            estat_d[21:16] = ws_ecode;
            estat_d[30:22] = ws_esubcode;
            if (ws_ecode == EcodeAde && ws_esubcode == EsubAdef) begin
                badv_d = ws_pc;
            end else if (ws_ecode == EcodeAle ||
                         (ws_ecode == EcodeAde && ws_esubcode == EsubAdem)) begin
                badv_d = ws_vaddr;
            end
        end else if (ertn) begin
            crmd_d[2:0] = prmd_q[2:0];
        end

        // A write loses to ws_ex/ertn only on the register those also update.
        if (csr_we) begin
            unique case (csr_num)
                CsrCrmd: begin
                    if (!ws_ex && !ertn) begin
                        crmd_d = wmerge(crmd_q, csr_wmask, csr_wvalue, CrmdWmask);
                    end
                end
                CsrPrmd: begin
                    if (!ws_ex) prmd_d = wmerge(prmd_q, csr_wmask, csr_wvalue, PrmdWmask);
                end
                CsrEcfg:  ecfg_d = wmerge(ecfg_q, csr_wmask, csr_wvalue, EcfgWmask);
                CsrEstat: begin
                    if (!ws_ex) estat_d = wmerge(estat_d, csr_wmask, csr_wvalue, EstatWmask);
                end
                CsrEra: begin
                    if (!ws_ex) era_d = wmerge(era_q, csr_wmask, csr_wvalue, 32'hffff_ffff);
                end
                CsrBadv: begin
                    if (!ws_ex) badv_d = wmerge(badv_q, csr_wmask, csr_wvalue, 32'hffff_ffff);
                end
                CsrEentry: eentry_d = wmerge(eentry_q, csr_wmask, csr_wvalue, EentryWmask);
                CsrSave0:  save_d[0] = wmerge(save_q[0], csr_wmask, csr_wvalue, 32'hffff_ffff);
                CsrSave1:  save_d[1] = wmerge(save_q[1], csr_wmask, csr_wvalue, 32'hffff_ffff);
                CsrSave2:  save_d[2] = wmerge(save_q[2], csr_wmask, csr_wvalue, 32'hffff_ffff);
                CsrSave3:  save_d[3] = wmerge(save_q[3], csr_wmask, csr_wvalue, 32'hffff_ffff);
                CsrTid:    tid_d = wmerge(tid_q, csr_wmask, csr_wvalue, 32'hffff_ffff);
                CsrTcfg: begin
                    tcfg_wr = 1'b1;
                    tcfg_d  = wmerge(tcfg_q, csr_wmask, csr_wvalue, TcfgWmask);
                end
                CsrTiclr:  ticlr_clr = csr_wmask[0] & csr_wvalue[0];
                default: ;
            endcase
        end

        // Timer: a fresh enable reloads; otherwise count down and fire at zero.
        if (tcfg_wr && tcfg_d[0]) begin
            tval_d = {tcfg_d[TIMER_W-1:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q == '0) begin
                timer_fire = 1'b1;
                tval_d     = tcfg_q[1] ? {tcfg_q[TIMER_W-1:2], 2'b00} : TvalOnes;
            end else if (tval_q != TvalOnes) begin
                tval_d = tval_q - 1'b1;
            end
        end

        // Timer set beats a same-cycle TICLR clear.
        if (timer_fire) begin
            estat_d[11] = 1'b1;
        end else if (ticlr_clr) begin
            estat_d[11] = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd_q   <= 32'h0000_0008;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            estat_q  <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            save_q   <= '0;
            tid_q    <= coreid_in;
            tcfg_q   <= '0;
            tval_q   <= TvalOnes;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            estat_q  <= estat_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            save_q   <= save_d;
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
        end
    end

    // Combinational read mux; unmapped addresses and TICLR read 0.
    always_comb begin
        csr_rvalue = '0;
        unique case (csr_num)
            CsrCrmd:   csr_rvalue = crmd_q;
            CsrPrmd:   csr_rvalue = prmd_q;
            CsrEcfg:   csr_rvalue = ecfg_q;
            CsrEstat:  csr_rvalue = estat_q;
            CsrEra:    csr_rvalue = era_q;
            CsrBadv:   csr_rvalue = badv_q;
            CsrEentry: csr_rvalue = eentry_q;
            CsrSave0:  csr_rvalue = save_q[0];
            CsrSave1:  csr_rvalue = save_q[1];
            CsrSave2:  csr_rvalue = save_q[2];
            CsrSave3:  csr_rvalue = save_q[3];
            CsrTid:    csr_rvalue = tid_q;
            CsrTcfg:   csr_rvalue = tcfg_q;
            CsrTval:   csr_rvalue = 32'(tval_q);
            default:   csr_rvalue = '0;
        endcase
    end

    // Outputs to WB, all straight from registered state.
    always_comb begin
        has_int   = crmd_q[2] & |(estat_q[12:0] & ecfg_q[12:0]);
        ex_entry  = eentry_q;
        era_entry = era_q;
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: field-level reference model plus
// directed scenarios with literal expectations.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ws_ex;
    logic [31:0] ws_pc;
    logic [5:0]  ws_ecode;
    logic [8:0]  ws_esubcode;
    logic [31:0] ws_vaddr;
    logic [31:0] coreid = 32'h0000_0005;
    logic        ertn;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] era_entry;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    csr_file #(.TIMER_W(32), .LIE_MASK(13'h1bff)) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_num    (csr_num),
        .csr_rvalue (csr_rvalue),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .ws_ex      (ws_ex),
        .ws_pc      (ws_pc),
        .ws_ecode   (ws_ecode),
        .ws_esubcode(ws_esubcode),
        .ws_vaddr   (ws_vaddr),
        .coreid_in  (coreid),
        .ertn       (ertn),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .has_int    (has_int),
        .ex_entry   (ex_entry),
        .era_entry  (era_entry)
    );

    always #10 clk = ~clk;

    // Reference model, kept as individual architectural fields.
    logic [5:0]       m_crmd_hi, n_crmd_hi;
    logic             m_ie, n_ie, m_pie, n_pie;
    logic [1:0]       m_plv, n_plv, m_pplv, n_pplv;
    logic [12:0]      m_lie, n_lie, m_is, n_is;
    logic [5:0]       m_ecode, n_ecode;
    logic [8:0]       m_esub, n_esub;
    logic [31:0]      m_era, n_era, m_badv, n_badv, m_eentry, n_eentry;
    logic [31:0]      m_tid, n_tid, m_tcfg, n_tcfg, m_tval, n_tval;
    logic [3:0][31:0] m_save, n_save;
    logic [31:0]      tmp;
    logic             fire, clr;

    function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] field,
                                        input logic [31:0] wm, input logic [31:0] wv);
        return (old & ~(wm & field)) | (wv & wm & field);
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] num);
        case (num)
            14'h000: return {23'b0, m_crmd_hi, m_ie, m_plv};
            14'h001: return {29'b0, m_pie, m_pplv};
            14'h004: return {19'b0, m_lie};
            14'h005: return {1'b0, m_esub, m_ecode, 3'b000, m_is};
            14'h006: return m_era;
            14'h007: return m_badv;
            14'h00c: return m_eentry;
            14'h030, 14'h031, 14'h032, 14'h033: return m_save[num[1:0]];
            14'h040: return m_tid;
            14'h041: return m_tcfg;
            14'h042: return m_tval;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        n_crmd_hi = m_crmd_hi; n_ie = m_ie; n_plv = m_plv; n_pie = m_pie; n_pplv = m_pplv;
        n_lie = m_lie; n_is = m_is; n_ecode = m_ecode; n_esub = m_esub; n_era = m_era;
        n_badv = m_badv; n_eentry = m_eentry; n_tid = m_tid; n_tcfg = m_tcfg;
        n_tval = m_tval; n_save = m_save; tmp = 32'h0; fire = 1'b0; clr = 1'b0;
        n_is[9:2] = hw_int_in;
        n_is[12]  = ipi_int_in;
        if (ws_ex) begin
            n_pplv = m_plv; n_pie = m_ie; n_plv = 2'd0; n_ie = 1'b0;
            n_era = ws_pc; n_ecode = ws_ecode; n_esub = ws_esubcode;
            if (ws_ecode == 6'h8 && ws_esubcode == 9'h0) n_badv = ws_pc;
            else if (ws_ecode == 6'h9 || (ws_ecode == 6'h8 && ws_esubcode == 9'h1))
                n_badv = ws_vaddr;
        end else if (ertn) begin
            n_plv = m_pplv; n_ie = m_pie;
        end
        if (csr_we) begin
            case (csr_num)
                14'h000: if (!ws_ex && !ertn) begin
                    tmp = upd({23'b0, m_crmd_hi, m_ie, m_plv}, 32'h1ff, csr_wmask, csr_wvalue);
                    n_crmd_hi = tmp[8:3]; n_ie = tmp[2]; n_plv = tmp[1:0];
                end
                14'h001: if (!ws_ex) begin
                    tmp = upd({29'b0, m_pie, m_pplv}, 32'h7, csr_wmask, csr_wvalue);
                    n_pie = tmp[2]; n_pplv = tmp[1:0];
                end
                14'h004: begin
                    tmp = upd({19'b0, m_lie}, 32'h1bff, csr_wmask, csr_wvalue);
                    n_lie = tmp[12:0];
                end
                14'h005: if (!ws_ex) begin
                    tmp = upd({30'b0, m_is[1:0]}, 32'h3, csr_wmask, csr_wvalue);
                    n_is[1:0] = tmp[1:0];
                end
                14'h006: if (!ws_ex) n_era = upd(m_era, '1, csr_wmask, csr_wvalue);
                14'h007: if (!ws_ex) n_badv = upd(m_badv, '1, csr_wmask, csr_wvalue);
                14'h00c: n_eentry = upd(m_eentry, 32'hffffffc0, csr_wmask, csr_wvalue);
                14'h030, 14'h031, 14'h032, 14'h033:
                    n_save[csr_num[1:0]] = upd(m_save[csr_num[1:0]], '1, csr_wmask, csr_wvalue);
                14'h040: n_tid = upd(m_tid, '1, csr_wmask, csr_wvalue);
                14'h041: n_tcfg = upd(m_tcfg, '1, csr_wmask, csr_wvalue);
                14'h044: clr = csr_wmask[0] && csr_wvalue[0];
                default: ;
            endcase
        end
        if (csr_we && csr_num == 14'h041 && n_tcfg[0]) begin
            n_tval = {n_tcfg[31:2], 2'b00};
        end else if (m_tcfg[0]) begin
            if (m_tval == 32'h0) begin
                fire = 1'b1;
                n_tval = m_tcfg[1] ? {m_tcfg[31:2], 2'b00} : 32'hffff_ffff;
            end else if (m_tval != 32'hffff_ffff) begin
                n_tval = m_tval - 32'd1;
            end
        end
        if (clr) n_is[11] = 1'b0;
        if (fire) n_is[11] = 1'b1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_crmd_hi <= 6'b000001; m_ie <= 1'b0; m_plv <= 2'd0; m_pie <= 1'b0; m_pplv <= 2'd0;
            m_lie <= '0; m_is <= '0; m_ecode <= '0; m_esub <= '0; m_era <= '0; m_badv <= '0;
            m_eentry <= '0; m_tid <= coreid; m_tcfg <= '0; m_tval <= 32'hffff_ffff;
            m_save <= '0;
        end else begin
            m_crmd_hi <= n_crmd_hi; m_ie <= n_ie; m_plv <= n_plv; m_pie <= n_pie;
            m_pplv <= n_pplv; m_lie <= n_lie; m_is <= n_is; m_ecode <= n_ecode;
            m_esub <= n_esub; m_era <= n_era; m_badv <= n_badv; m_eentry <= n_eentry;
            m_tid <= n_tid; m_tcfg <= n_tcfg; m_tval <= n_tval; m_save <= n_save;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk($sformatf("rvalue[%03h]", csr_num), csr_rvalue, model_read(csr_num));
            chk("has_int", {31'b0, has_int}, {31'b0, m_ie && ((m_is & m_lie) != 13'h0)});
            chk("ex_entry", ex_entry, m_eentry);
            chk("era_entry", era_entry, m_era);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        ws_ex  = 1'b0;
        ertn   = 1'b0;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    endtask

    task automatic rd(input logic [13:0] num, input logic [31:0] exp, input string nm);
        csr_num = num;
        #1;
        chk(nm, csr_rvalue, exp);
    endtask

    initial begin
        csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0; ws_ex = 1'b0;
        ws_pc = '0; ws_ecode = '0; ws_esubcode = '0; ws_vaddr = '0; ertn = 1'b0;
        hw_int_in = '0; ipi_int_in = 1'b0;
        #3 reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        rd(14'h000, 32'h8, "reset crmd");
        rd(14'h040, 32'h5, "reset tid");
        rd(14'h042, 32'hffffffff, "reset tval");
        rd(14'h001, 32'h0, "reset prmd");
        chk("reset has_int", {31'b0, has_int}, 32'h0);
        chk("reset ex_entry", ex_entry, 32'h0);
        chk("reset era_entry", era_entry, 32'h0);

        // Writable-field masking and unmapped addresses.
        wr(14'h004, '1, '1); cyc();
        rd(14'h004, 32'h1bff, "ecfg lie mask");
        wr(14'h004, '1, 32'h0); cyc();
        rd(14'h004, 32'h0, "ecfg cleared");
        wr(14'h00c, '1, '1); cyc();
        rd(14'h00c, 32'hffffffc0, "eentry low bits");
        wr(14'h00c, '1, 32'h1c008000); cyc();
        chk("ex_entry", ex_entry, 32'h1c008000);
        wr(14'h005, '1, '1); cyc();
        rd(14'h005, 32'h3, "estat sw bits");
        wr(14'h005, '1, 32'h0); cyc();
        rd(14'h005, 32'h0, "estat cleared");
        wr(14'h3ff, '1, '1); cyc();
        rd(14'h3ff, 32'h0, "unmapped read");

        // Masked write, same-cycle read returns old value.
        wr(14'h031, 32'h0000ffff, 32'h12345678);
        rd(14'h031, 32'h0, "save1 same cycle");
        cyc();
        rd(14'h031, 32'h00005678, "save1 masked");

        // Exception then ertn.
        wr(14'h000, '1, 32'h7); cyc();
        ws_ex = 1'b1; ws_ecode = 6'h09; ws_esubcode = 9'h0; ws_vaddr = 32'h1003;
        ws_pc = 32'h1c000100;
        rd(14'h000, 32'h7, "crmd before ex");
        chk("era_entry pre-ex", era_entry, 32'h0);
        cyc();
        rd(14'h000, 32'h0, "crmd after ex");
        rd(14'h001, 32'h7, "prmd after ex");
        rd(14'h006, 32'h1c000100, "era after ex");
        rd(14'h007, 32'h1003, "badv ale");
        rd(14'h005, 32'h00090000, "estat ecode");
        chk("era_entry", era_entry, 32'h1c000100);
        ertn = 1'b1;
        cyc();
        rd(14'h000, 32'h7, "crmd after ertn");

        // One-shot timer.
        wr(14'h004, '1, 32'h800); cyc();
        wr(14'h041, '1, 32'h9); cyc();
        for (int i = 0; i < 9; i++) begin
            rd(14'h042, 32'(8 - i), "oneshot tval");
            cyc();
        end
        rd(14'h042, 32'hffffffff, "oneshot stop");
        rd(14'h005, 32'h00090800, "oneshot is11");
        chk("oneshot has_int", {31'b0, has_int}, 32'h1);
        cyc();
        rd(14'h042, 32'hffffffff, "oneshot hold");
        wr(14'h044, 32'h1, 32'h1);
        chk("ticlr same cycle", {31'b0, has_int}, 32'h1);
        cyc();
        chk("ticlr cleared", {31'b0, has_int}, 32'h0);
        rd(14'h005, 32'h00090000, "estat after ticlr");

        // Periodic timer; a clear coinciding with a fire loses.
        wr(14'h041, '1, 32'hb); cyc();
        for (int k = 1; k <= 20; k++) begin
            rd(14'h042, 32'(8 - ((k - 1) % 9)), "periodic tval");
            chk("periodic has_int", {31'b0, has_int},
                (k == 10 || k >= 19) ? 32'h1 : 32'h0);
            if (k == 10 || k == 18) wr(14'h044, 32'h1, 32'h1);
            cyc();
        end
        wr(14'h041, '1, 32'h0); cyc();
        wr(14'h044, 32'h1, 32'h1); cyc();
        chk("timer off has_int", {31'b0, has_int}, 32'h0);

        // Exception beats a same-cycle CRMD write; ADEF records the PC.
        ws_ex = 1'b1; ws_ecode = 6'h08; ws_esubcode = 9'h0; ws_pc = 32'h1c000200;
        ws_vaddr = 32'h55;
        wr(14'h000, '1, 32'h3);
        cyc();
        rd(14'h000, 32'h0, "collision crmd");
        rd(14'h001, 32'h7, "collision prmd");
        rd(14'h007, 32'h1c000200, "badv adef");
        rd(14'h005, 32'h00080000, "estat ade");
        rd(14'h006, 32'h1c000200, "era ade");
        rd(14'h3ff, 32'h0, "unmapped 3ff");

        // Asynchronous reset during countdown.
        wr(14'h000, '1, 32'h4); cyc();
        wr(14'h004, '1, 32'h804); cyc();
        wr(14'h041, '1, 32'h41); cyc();
        cyc();
        rd(14'h042, 32'h3f, "countdown before reset");
        hw_int_in = 8'h01;
        cyc();
        chk("has_int before reset", {31'b0, has_int}, 32'h1);
        #4 reset = 1'b1;
        #1;
        chk("async has_int", {31'b0, has_int}, 32'h0);
        rd(14'h042, 32'hffffffff, "async tval");
        rd(14'h000, 32'h8, "async crmd");
        chk("async ex_entry", ex_entry, 32'h0);
        chk("async era_entry", era_entry, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        rd(14'h005, 32'h0, "is before sample");
        cyc();
        rd(14'h005, 32'h4, "hw int sampled");
        chk("hw int no ie", {31'b0, has_int}, 32'h0);
        ipi_int_in = 1'b1;
        cyc();
        rd(14'h005, 32'h1004, "ipi sampled");
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
